// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag values, operand marker, opcodes, station state encoding
// and the CDB snoop match used by the reservation stations.
package tomasulo_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 4;

    localparam logic [TAG_W-1:0] FREE_REGISTER    = 3'd0;
    localparam logic [TAG_W-1:0] RES_STATION_ADD1 = 3'd1;
    localparam logic [TAG_W-1:0] RES_STATION_ADD2 = 3'd2;

    localparam logic [DATA_W-1:0] Vj_Vk_sem_valor = 16'hFFF0;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;

    typedef enum logic [1:0] {
        LIVRE     = 2'd0,
        ESPERA    = 2'd1,
        EXECUTA   = 2'd2,
        RESULTADO = 2'd3
    } rs_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
    } rs_entry_t;

    // A pending operand is satisfied by a broadcast from another station carrying its tag.
    function automatic logic cdb_hit(input logic [TAG_W-1:0] q,
                                     input logic [TAG_W-1:0] own,
                                     input logic             valid,
                                     input logic [TAG_W-1:0] tag);
        return valid && (q != FREE_REGISTER) && (q == tag) && (q != own);
    endfunction

endpackage

// File: rtl/unidade_soma.sv
// Combinational 16-bit adder/subtractor. The subtract path exists only when RS_SUB_EN is
// defined; otherwise every operation is an add and the sub select is unused.
module unidade_soma
    import tomasulo_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] y_c
);

`ifdef RS_SUB_EN
    always_comb begin
        y_c = sub ? DATA_W'(a - b) : DATA_W'(a + b);
    end
`else
    logic unused_sub;
    assign unused_sub = sub;

    always_comb begin
        y_c = DATA_W'(a + b);
    end
`endif

endmodule

// File: rtl/estacao_reserva_add.sv
// Single-entry add/sub reservation station: captures operands from dispatch or the CDB,
// executes for EXEC_LATENCY cycles, then holds its result on the CDB request until granted.
// Subtraction is built only with RS_SUB_EN defined (see unidade_soma).
module estacao_reserva_add
    import tomasulo_pkg::*;
#(
    parameter logic [TAG_W-1:0] TAG          = RES_STATION_ADD1,
    parameter int unsigned      EXEC_LATENCY = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [OP_W-1:0]   Opcode,
    input  logic [DATA_W-1:0] Vj,
    input  logic [DATA_W-1:0] Vk,
    input  logic [TAG_W-1:0]  Qj,
    input  logic [TAG_W-1:0]  Qk,
    input  logic              CDB_Valid,
    input  logic [TAG_W-1:0]  CDB_Tag,
    input  logic [DATA_W-1:0] CDB_Data,
    input  logic              CDB_Grant,
    output logic              Ready,
    output logic              Result_Req,
    output logic [TAG_W-1:0]  Result_Tag,
    output logic [DATA_W-1:0] Result_Data
);

    localparam rs_entry_t ENTRY_RESET = '{
        op: OP_ADD,
        vj: Vj_Vk_sem_valor,
        vk: Vj_Vk_sem_valor,
        qj: FREE_REGISTER,
        qk: FREE_REGISTER
    };

    rs_state_e         state_q, state_d;
    rs_entry_t         ent_q, ent_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carga_q, carga_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ready_q, ready_d;
    logic              req_q, req_d;

    logic              hit_in_j_c, hit_in_k_c;
    logic              hit_j_c, hit_k_c;
    logic              sub_sel_c;
    logic [DATA_W-1:0] soma_c;

    assign sub_sel_c = (ent_q.op == OP_SUB);

    unidade_soma u_soma (
        .a   (ent_q.vj),
        .b   (ent_q.vk),
        .sub (sub_sel_c),
        .y_c (soma_c)
    );

    // Snoop matches: incoming dispatch tags (forwarding) and already-latched tags.
    assign hit_in_j_c = cdb_hit(Qj, TAG, CDB_Valid, CDB_Tag);
    assign hit_in_k_c = cdb_hit(Qk, TAG, CDB_Valid, CDB_Tag);
    assign hit_j_c    = cdb_hit(ent_q.qj, TAG, CDB_Valid, CDB_Tag);
    assign hit_k_c    = cdb_hit(ent_q.qk, TAG, CDB_Valid, CDB_Tag);

    always_comb begin
        state_d  = state_q;
        ent_d    = ent_q;
        cnt_d    = cnt_q;
        carga_d  = 1'b0;
        result_d = result_q;

        case (state_q)
            LIVRE: begin
                if (Enable) begin
                    ent_d.op = Opcode;
                    ent_d.vj = hit_in_j_c ? CDB_Data : Vj;
                    ent_d.qj = hit_in_j_c ? FREE_REGISTER : Qj;
                    ent_d.vk = hit_in_k_c ? CDB_Data : Vk;
                    ent_d.qk = hit_in_k_c ? FREE_REGISTER : Qk;
                    if ((ent_d.qj == FREE_REGISTER) && (ent_d.qk == FREE_REGISTER)) begin
                        state_d = EXECUTA;
                        carga_d = 1'b1;
                    end else begin
                        state_d = ESPERA;
                    end
                end
            end
            ESPERA: begin
                if (hit_j_c) begin
                    ent_d.vj = CDB_Data;
                    ent_d.qj = FREE_REGISTER;
                end
                if (hit_k_c) begin
                    ent_d.vk = CDB_Data;
                    ent_d.qk = FREE_REGISTER;
                end
                if ((ent_d.qj == FREE_REGISTER) && (ent_d.qk == FREE_REGISTER)) begin
                    state_d = EXECUTA;
                    carga_d = 1'b1;
                end
            end
            EXECUTA: begin
                // First cycle in EXECUTA loads the counter; the result registers at count 0.
                if (carga_q) begin
                    cnt_d = CNT_W'(EXEC_LATENCY - 1);
                end else if (cnt_q == '0) begin
                    result_d = soma_c;
                    state_d  = RESULTADO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESULTADO: begin
                if (CDB_Grant) begin
                    state_d = LIVRE;
                end
            end
            default: begin
                state_d = LIVRE;
            end
        endcase

        ready_d = (state_d == LIVRE);
        req_d   = (state_d == RESULTADO);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= LIVRE;
            ent_q    <= ENTRY_RESET;
            cnt_q    <= '0;
            carga_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b1;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ent_q    <= ent_d;
            cnt_q    <= cnt_d;
            carga_q  <= carga_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            req_q    <= req_d;
        end
    end

    assign Ready       = ready_q;
    assign Result_Req  = req_q;
    assign Result_Tag  = TAG;
    assign Result_Data = result_q;

endmodule

// File: tb/tb_estacao_reserva_add.sv
// Directed, table-driven bench for estacao_reserva_add (instance TAG=2, EXEC_LATENCY=2).
module tb_estacao_reserva_add;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic [2:0]  Opcode;
    logic [15:0] Vj, Vk;
    logic [2:0]  Qj, Qk;
    logic        CDB_Valid;
    logic [2:0]  CDB_Tag;
    logic [15:0] CDB_Data;
    logic        CDB_Grant;
    logic        Ready;
    logic        Result_Req;
    logic [2:0]  Result_Tag;
    logic [15:0] Result_Data;

    estacao_reserva_add #(.TAG(3'd2), .EXEC_LATENCY(2)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enable      (Enable),
        .Opcode      (Opcode),
        .Vj          (Vj),
        .Vk          (Vk),
        .Qj          (Qj),
        .Qk          (Qk),
        .CDB_Valid   (CDB_Valid),
        .CDB_Tag     (CDB_Tag),
        .CDB_Data    (CDB_Data),
        .CDB_Grant   (CDB_Grant),
        .Ready       (Ready),
        .Result_Req  (Result_Req),
        .Result_Tag  (Result_Tag),
        .Result_Data (Result_Data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] vj;
        logic [15:0] vk;
        logic [2:0]  qj;
        logic [2:0]  qk;
        logic        fwd;
        int          cdb_at;
        logic [2:0]  cdb_tag;
        logic [15:0] cdb_data;
        int          hold;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        Enable    = 1'b0;
        Opcode    = 3'd0;
        Vj        = 16'h0;
        Vk        = 16'h0;
        Qj        = 3'd0;
        Qk        = 3'd0;
        CDB_Valid = 1'b0;
        CDB_Tag   = 3'd0;
        CDB_Data  = 16'h0;
        CDB_Grant = 1'b0;
    endtask

    // Called #1 after a rising edge; returns #1 after the grant edge.
    task automatic run_vec(input int idx, input vec_t v);
        int          n;
        logic [15:0] held;
        string       tagname;
        tagname   = $sformatf("v%0d", idx);
        Enable    = 1'b1;
        Opcode    = v.op;
        Vj        = v.vj;
        Vk        = v.vk;
        Qj        = v.qj;
        Qk        = v.qk;
        if (v.fwd) begin
            CDB_Valid = 1'b1;
            CDB_Tag   = v.cdb_tag;
            CDB_Data  = v.cdb_data;
        end
        @(posedge Clock); #1;
        idle_inputs();
        chk({tagname, "_ready_low"}, 32'(Ready), 32'd0);
        n = 0;
        while (!Result_Req && n < 40) begin
            if (v.cdb_at != 0 && n + 1 == v.cdb_at) begin
                CDB_Valid = 1'b1;
                CDB_Tag   = v.cdb_tag;
                CDB_Data  = v.cdb_data;
            end
            @(posedge Clock); #1;
            CDB_Valid = 1'b0;
            n++;
        end
        chk({tagname, "_latency"}, 32'(n), 32'(v.exp_lat));
        chk({tagname, "_data"}, 32'(Result_Data), 32'(v.exp_data));
        held = Result_Data;
        for (int h = 0; h < v.hold; h++) begin
            Enable = 1'b1;
            Opcode = 3'd0;
            Vj     = 16'h1234;
            Vk     = 16'h4321;
            @(posedge Clock); #1;
            Enable = 1'b0;
            chk({tagname, "_hold_req"}, 32'(Result_Req), 32'd1);
            chk({tagname, "_hold_data"}, 32'(Result_Data), 32'(held));
        end
        CDB_Grant = 1'b1;
        @(posedge Clock); #1;
        CDB_Grant = 1'b0;
        chk({tagname, "_grant_ready"}, 32'(Ready), 32'd1);
        chk({tagname, "_grant_req"}, 32'(Result_Req), 32'd0);
    endtask

    initial begin
        //        op    vj        vk        qj    qk    fwd   at tag   cdb_data  hold exp_data  lat
        vecs[0] = '{3'd0, 16'd5,    16'd7,    3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 0, 16'd12,   3};
        vecs[1] = '{3'd0, 16'h0000, 16'd3,    3'd1, 3'd0, 1'b0, 2, 3'd1, 16'd10,   0, 16'd13,   5};
        vecs[2] = '{3'd0, 16'd1,    16'h0000, 3'd0, 3'd1, 1'b1, 0, 3'd1, 16'h0004, 0, 16'd5,    3};
`ifdef RS_SUB_EN
        vecs[3] = '{3'd1, 16'h0000, 16'h0001, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 0, 16'hFFFF, 3};
        vecs[7] = '{3'd1, 16'h0010, 16'h0003, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 0, 16'h000D, 3};
`else
        vecs[3] = '{3'd1, 16'h0000, 16'h0001, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 0, 16'h0001, 3};
        vecs[7] = '{3'd1, 16'h0010, 16'h0003, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 0, 16'h0013, 3};
`endif
        vecs[4] = '{3'd0, 16'hFFFF, 16'h0002, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 5, 16'h0001, 3};
        vecs[5] = '{3'd5, 16'd10,   16'd3,    3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 0, 16'd13,   3};
        vecs[6] = '{3'd0, 16'h0000, 16'h0000, 3'd1, 3'd1, 1'b0, 1, 3'd1, 16'd7,    0, 16'd14,   4};

        idle_inputs();
        Reset = 1'b0;
        #12;
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_req", 32'(Result_Req), 32'd0);
        chk("rst_data", 32'(Result_Data), 32'h0000);
        chk("rst_tag", 32'(Result_Tag), 32'd2);
        Reset = 1'b1;
        @(posedge Clock); #1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Asynchronous reset in the middle of execution.
        Enable = 1'b1; Opcode = 3'd0; Vj = 16'd5; Vk = 16'd7; Qj = 3'd0; Qk = 3'd0;
        @(posedge Clock); #1;
        idle_inputs();
        @(posedge Clock); #1;
        chk("exec_busy", 32'(Ready), 32'd0);
        #2 Reset = 1'b0;
        #1;
        chk("arst_ready", 32'(Ready), 32'd1);
        chk("arst_req", 32'(Result_Req), 32'd0);
        chk("arst_data", 32'(Result_Data), 32'h0000);
        #1 Reset = 1'b1;
        @(posedge Clock); #1;
        run_vec(100, vecs[0]);

        // Own-tag broadcasts never satisfy a pending operand; the station stays waiting.
        Enable = 1'b1; Opcode = 3'd0; Vj = 16'd0; Vk = 16'd1; Qj = 3'd2; Qk = 3'd0;
        @(posedge Clock); #1;
        idle_inputs();
        CDB_Valid = 1'b1; CDB_Tag = 3'd2; CDB_Data = 16'd9;
        repeat (6) @(posedge Clock);
        #1;
        idle_inputs();
        chk("own_tag_req", 32'(Result_Req), 32'd0);
        chk("own_tag_busy", 32'(Ready), 32'd0);
        Reset = 1'b0;
        #1;
        chk("own_tag_rst_ready", 32'(Ready), 32'd1);
        #1 Reset = 1'b1;
        @(posedge Clock); #1;
        run_vec(101, vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
